// File: rtl/stack_cpu_core.sv
// Control and datapath core of the 8-bit stack processor: fetches the stack ISA
// from a negedge-clocked unified memory and executes it on an internal LIFO.
module stack_cpu_core #(
   parameter int STACK_DEPTH = 16,
   parameter int SP_W        = 5
) (
   input  logic            clk,
   input  logic            resetN,
   input  logic [7:0]      data_out,
   output logic [7:0]      address,
   output logic            readwriteN,
   output logic [7:0]      data_in,
   output logic            halted,
   output logic            error,
   output logic [7:0]      tos,
   output logic [SP_W-1:0] sp
);
   localparam int IDX_W = $clog2(STACK_DEPTH);

   localparam logic [7:0] OP_PUSHC  = 8'h00;
   localparam logic [7:0] OP_PUSH   = 8'h01;
   localparam logic [7:0] OP_POP    = 8'h02;
   localparam logic [7:0] OP_ADD    = 8'h06;
   localparam logic [7:0] OP_SUB    = 8'h07;
   localparam logic [7:0] OP_FINISH = 8'h0F;

   typedef enum logic [1:0] {FETCH, OPERAND, EXEC, HALT} state_t;

   state_t          state_q, state_d;
   logic [7:0]      pc_q, pc_d, ir_q, ir_d, opr_q, opr_d;
   logic [SP_W-1:0] sp_q, sp_d;
   logic            halted_q, halted_d, error_q, error_d;

   logic [7:0]      stack_q [STACK_DEPTH];
   logic            stk_we;
   logic [IDX_W-1:0] stk_widx;
   logic [7:0]      stk_wdata;
   logic [7:0]      top_a, top_b;
   logic            stk_empty, stk_full, stk_lt2, fault;

   always_comb begin
      stk_empty = (sp_q == '0);
      stk_full  = (sp_q == SP_W'(STACK_DEPTH));
      stk_lt2   = (sp_q < SP_W'(2));
      top_a     = stk_empty ? 8'h00 : stack_q[IDX_W'(sp_q - SP_W'(1))];
      top_b     = stk_lt2   ? 8'h00 : stack_q[IDX_W'(sp_q - SP_W'(2))];
   end

   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      opr_d     = opr_q;
      sp_d      = sp_q;
      halted_d  = halted_q;
      error_d   = error_q;
      stk_we    = 1'b0;
      stk_widx  = IDX_W'(sp_q);
      stk_wdata = opr_q;
      fault     = 1'b0;
      unique case (state_q)
         FETCH: begin
            ir_d    = data_out;
            pc_d    = pc_q + 8'd1;
            state_d = (data_out <= OP_POP) ? OPERAND : EXEC;
         end
         OPERAND: begin
            opr_d   = data_out;
            pc_d    = pc_q + 8'd1;
            state_d = EXEC;
         end
         EXEC: begin
            state_d = FETCH;
            case (ir_q)
               OP_PUSHC, OP_PUSH: begin
                  if (stk_full) fault = 1'b1;
                  else begin
                     stk_we    = 1'b1;
                     stk_wdata = (ir_q == OP_PUSHC) ? opr_q : data_out;
                     sp_d      = sp_q + SP_W'(1);
                  end
               end
               OP_POP: begin
                  if (stk_empty) fault = 1'b1;
                  else sp_d = sp_q - SP_W'(1);
               end
               OP_ADD, OP_SUB: begin
                  // Result lands in B's slot, so the net effect is one pop.
                  if (stk_lt2) fault = 1'b1;
                  else begin
                     stk_we    = 1'b1;
                     stk_widx  = IDX_W'(sp_q - SP_W'(2));
                     stk_wdata = (ir_q == OP_ADD) ? (top_a + top_b) : (top_a - top_b);
                     sp_d      = sp_q - SP_W'(1);
                  end
               end
               OP_FINISH: begin
                  state_d  = HALT;
                  halted_d = 1'b1;
               end
               default: fault = 1'b1;
            endcase
         end
         HALT: ;
         default: state_d = FETCH;
      endcase
      if (fault) begin
         state_d  = HALT;
         halted_d = 1'b1;
         error_d  = 1'b1;
         sp_d     = sp_q;
         stk_we   = 1'b0;
      end
   end

   always_comb begin
      address    = pc_q;
      readwriteN = 1'b1;
      data_in    = 8'h00;
      if (state_q == EXEC) begin
         if (ir_q == OP_PUSH) address = opr_q;
         if (ir_q == OP_POP) begin
            address    = opr_q;
            data_in    = top_a;
            readwriteN = stk_empty;
         end
      end
   end

   // NOTE: non-blocking assignments so all state updates see pre-edge values.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q  <= FETCH;
         pc_q     <= 8'h00;
         ir_q     <= 8'h00;
         opr_q    <= 8'h00;
         sp_q     <= '0;
         halted_q <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         opr_q    <= opr_d;
         sp_q     <= sp_d;
         halted_q <= halted_d;
         error_q  <= error_d;
      end
   end

   // NOTE: stack storage is not reset; sp alone defines which entries are valid.
   always_ff @(posedge clk) begin
      if (stk_we) stack_q[stk_widx] <= stk_wdata;
   end

   assign halted = halted_q;
   assign error  = error_q;
   assign tos    = top_a;
   assign sp     = sp_q;
endmodule
